// File: rtl/acia_tx_sched.sv
// Round-robin scheduler sharing one ACIA transmitter between NREQ byte sources.
// Initialises the ACIA, then polls status and writes each granted byte to TX data.
module acia_tx_sched #(
    parameter int          NREQ     = 2,
    parameter logic [7:0]  CFG_BYTE = 8'h00,
    parameter int          POLL_GAP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    output logic                acia_cs,
    output logic                acia_we,
    output logic                acia_rs,
    output logic [7:0]          acia_din,
    input  logic [7:0]          acia_dout,
    output logic                init_done,
    output logic                busy,
    output logic [2:0]          grant_id
);

    localparam int CW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        INIT_MR, INIT_CFG, IDLE, ARB, POLL_RD, POLL_CHK, POLL_WAIT, WRITE
    } state_t;

    state_t          state, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [7:0]      hold_q, hold_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cs_d, we_d, rs_d, init_d, busy_d;
    logic [7:0]      din_d;
    logic [NREQ-1:0] ack_d;
    logic [2:0]      grant_d;

    logic [7:0]      req_pad;
    logic [7:0][7:0] data_pad;
    logic            arb_hit;
    logic [2:0]      arb_idx;
    logic            dout_unused;

    // Pad to 8 requesters so a 3-bit index always selects in range.
    assign req_pad     = 8'(req);
    assign data_pad    = 64'(req_data);
    assign dout_unused = ^{acia_dout[7:2], acia_dout[0]};

    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!arb_hit && req_pad[3'((int'(ptr_q) + off) % NREQ)]) begin
                arb_hit = 1'b1;
                arb_idx = 3'((int'(ptr_q) + off) % NREQ);
            end
        end
    end

    // Bus actions are registered on the transition, so a status read issued
    // when entering POLL_RD has its registered result ready in POLL_CHK.
    always_comb begin
        state_d = state;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        rs_d    = 1'b0;
        din_d   = acia_din;
        ack_d   = '0;
        init_d  = init_done;
        busy_d  = 1'b1;
        grant_d = grant_id;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state)
            INIT_MR: begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                din_d   = 8'h03;
                state_d = INIT_CFG;
            end
            INIT_CFG: begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                din_d   = CFG_BYTE;
                init_d  = 1'b1;
                state_d = IDLE;
            end
            IDLE: begin
                busy_d = 1'b0;
                if (|req) state_d = ARB;
            end
            ARB: begin
                if (arb_hit) begin
                    grant_d = arb_idx;
                    ptr_d   = arb_idx;
                    hold_d  = data_pad[arb_idx];
                    cs_d    = 1'b1;
                    state_d = POLL_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            POLL_RD: state_d = POLL_CHK;
            POLL_CHK: begin
                if (acia_dout[1]) begin
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                    rs_d    = 1'b1;
                    din_d   = hold_q;
                    ack_d   = NREQ'(8'(1) << grant_id);
                    state_d = WRITE;
                end else begin
                    cnt_d   = CW'(POLL_GAP - 1);
                    state_d = POLL_WAIT;
                end
            end
            POLL_WAIT: begin
                if (cnt_q == '0) begin
                    cs_d    = 1'b1;
                    state_d = POLL_RD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = INIT_MR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT_MR;
            ptr_q     <= 3'(NREQ - 1);
            hold_q    <= '0;
            cnt_q     <= '0;
            acia_cs   <= 1'b0;
            acia_we   <= 1'b0;
            acia_rs   <= 1'b0;
            acia_din  <= '0;
            ack       <= '0;
            init_done <= 1'b0;
            busy      <= 1'b1;
            grant_id  <= '0;
        end else begin
            state     <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            acia_cs   <= cs_d;
            acia_we   <= we_d;
            acia_rs   <= rs_d;
            acia_din  <= din_d;
            ack       <= ack_d;
            init_done <= init_d;
            busy      <= busy_d;
            grant_id  <= grant_d;
        end
    end

endmodule

// File: tb/tb_acia_tx_sched.sv
// Directed bench for acia_tx_sched with a small ACIA register-port model.
module tb_acia_tx_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  ack;
    logic        acia_cs, acia_we, acia_rs;
    logic [7:0]  acia_din;
    logic [7:0]  acia_dout = 8'h00;
    logic        init_done, busy;
    logic [2:0]  grant_id;

    int checks = 0;
    int failures = 0;

    // ACIA model state and bus logs
    int          cyc = 0;
    int          stat_busy_n = 0;
    int          ack_cnt = 0;
    int          rd_cyc[$];
    logic [7:0]  ctl_q[$];
    logic [12:0] wr_q[$];

    acia_tx_sched #(.NREQ(2), .CFG_BYTE(8'h15), .POLL_GAP(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .acia_cs(acia_cs), .acia_we(acia_we), .acia_rs(acia_rs),
        .acia_din(acia_din), .acia_dout(acia_dout), .init_done(init_done),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (|ack) ack_cnt++;
        if (acia_cs && !acia_we && !acia_rs) begin
            rd_cyc.push_back(cyc);
            if (stat_busy_n > 0) begin
                acia_dout <= 8'h00;
                stat_busy_n--;
            end else begin
                acia_dout <= 8'h02;
            end
        end
        if (acia_cs && acia_we && !acia_rs) ctl_q.push_back(acia_din);
        if (acia_cs && acia_we && acia_rs)  wr_q.push_back({ack, grant_id, acia_din});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int a0;
        logic [12:0] e;

        // Reset state
        step(3);
        chk("rst_cs", acia_cs, 0);
        chk("rst_we", acia_we, 0);
        chk("rst_rs", acia_rs, 0);
        chk("rst_din", acia_din, 0);
        chk("rst_ack", ack, 0);
        chk("rst_init", init_done, 0);
        chk("rst_busy", busy, 1);
        chk("rst_grant", grant_id, 0);

        // Initialisation writes
        rst = 1'b1;
        step(1);
        chk("mr_strobe", {acia_cs, acia_we, acia_rs}, 3'b110);
        chk("mr_din", acia_din, 8'h03);
        chk("mr_init", init_done, 0);
        step(1);
        chk("cfg_strobe", {acia_cs, acia_we, acia_rs}, 3'b110);
        chk("cfg_din", acia_din, 8'h15);
        chk("cfg_init", init_done, 1);
        chk("cfg_busy", busy, 1);
        step(1);
        chk("idle_cs", acia_cs, 0);
        chk("idle_busy", busy, 0);
        step(2);

        // Contention: both requesters held, strict alternation starting at 0
        wr_q.delete();
        req_data = {8'h55, 8'hAA};
        req = 2'b11;
        n = 0;
        while (wr_q.size() < 4 && n < 100) begin step(1); n++; end
        req = 2'b00;
        chk("cont_count", wr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            e = (i < wr_q.size()) ? wr_q[i] : 13'h0;
            chk("cont_din",   e[7:0],   (i % 2 == 0) ? 8'hAA : 8'h55);
            chk("cont_grant", e[10:8],  (i % 2 == 0) ? 3'd0 : 3'd1);
            chk("cont_ack",   e[12:11], (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        step(3);

        // Single request, exact cycle timing
        wr_q.delete();
        rd_cyc.delete();
        req_data = {8'h00, 8'h41};
        req = 2'b01;
        step(1);
        chk("s_arb_cs", acia_cs, 0);
        chk("s_arb_busy", busy, 0);
        step(1);
        chk("s_rd_strobe", {acia_cs, acia_we, acia_rs}, 3'b100);
        chk("s_rd_grant", grant_id, 0);
        chk("s_rd_busy", busy, 1);
        step(1);
        chk("s_chk_cs", acia_cs, 0);
        chk("s_chk_ack", ack, 0);
        step(1);
        chk("s_wr_strobe", {acia_cs, acia_we, acia_rs}, 3'b111);
        chk("s_wr_din", acia_din, 8'h41);
        chk("s_wr_ack", ack, 2'b01);
        req = 2'b00;
        step(1);
        chk("s_post_ack", ack, 0);
        chk("s_post_cs", acia_cs, 0);
        chk("s_reads", rd_cyc.size(), 1);
        chk("s_din_hold", acia_din, 8'h41);
        step(3);

        // Busy transmitter: three not-empty polls before the write
        wr_q.delete();
        rd_cyc.delete();
        a0 = ack_cnt;
        stat_busy_n = 3;
        req_data = {8'h77, 8'h00};
        req = 2'b10;
        n = 0;
        while (wr_q.size() < 1 && n < 200) begin step(1); n++; end
        req = 2'b00;
        chk("b_writes", wr_q.size(), 1);
        chk("b_reads", rd_cyc.size(), 4);
        for (int i = 1; i < 4; i++)
            chk("b_gap", (i < rd_cyc.size()) ? rd_cyc[i] - rd_cyc[i-1] : 0, 6);
        e = (wr_q.size() > 0) ? wr_q[0] : 13'h0;
        chk("b_din", e[7:0], 8'h77);
        chk("b_ack", e[12:11], 2'b10);
        chk("b_ackcnt", ack_cnt - a0, 1);
        step(3);

        // Withdrawn request: one-cycle pulse in IDLE
        rd_cyc.delete();
        wr_q.delete();
        a0 = ack_cnt;
        req = 2'b01;
        step(1);
        req = 2'b00;
        step(10);
        chk("w_reads", rd_cyc.size(), 0);
        chk("w_writes", wr_q.size(), 0);
        chk("w_acks", ack_cnt - a0, 0);
        chk("w_busy", busy, 0);
        chk("w_grant", grant_id, 1);

        // Reset while polling a busy transmitter
        rd_cyc.delete();
        a0 = ack_cnt;
        stat_busy_n = 100;
        req_data = {8'h00, 8'h41};
        req = 2'b01;
        n = 0;
        while (rd_cyc.size() < 1 && n < 20) begin step(1); n++; end
        chk("m_first_read", rd_cyc.size(), 1);
        step(2);
        #2 rst = 1'b0;
        #1;
        chk("m_cs", {acia_cs, acia_we, acia_rs}, 3'b000);
        chk("m_din", acia_din, 0);
        chk("m_init", init_done, 0);
        chk("m_busy", busy, 1);
        chk("m_grant", grant_id, 0);
        req = 2'b00;
        stat_busy_n = 0;
        step(2);
        ctl_q.delete();
        wr_q.delete();
        rst = 1'b1;
        n = 0;
        while (ctl_q.size() < 2 && n < 20) begin step(1); n++; end
        chk("m_ctl_count", ctl_q.size(), 2);
        chk("m_ctl0", (ctl_q.size() > 0) ? ctl_q[0] : 8'hxx, 8'h03);
        chk("m_ctl1", (ctl_q.size() > 1) ? ctl_q[1] : 8'hxx, 8'h15);
        chk("m_no_write", wr_q.size(), 0);
        step(3);
        chk("m_acks", ack_cnt - a0, 0);
        chk("m_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
